// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multi-cycle main control unit.
// Holds the RV32 opcode and funct constants, the ALUOp and datapath mux
// encodings, the FSM state enum and the instruction class enum produced
// by the legality decoder.
package controle_multiciclo_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CL_LOAD   = 3'd0,
        CL_STORE  = 3'd1,
        CL_RTYPE  = 3'd2,
        CL_IALU   = 3'd3,
        CL_BRANCH = 3'd4,
        CL_NONE   = 3'd5
    } instr_class_t;

endpackage

// File: rtl/controle_multiciclo_decodificador_legalidade.sv
// Combinational legality decoder.
// Maps the IR fields to an instruction class and a legal flag; shared by
// the DECODE and MEMADR states of the control FSM.
// Ports:
//   opcode_i, funct3_i, funct7_i : instruction fields from IR
//   instr_class_o                : class of a supported instruction
//   legal_o                      : 1 when the encoding is supported
module decodificador_legalidade
    import controle_multiciclo_pkg::*;
(
    input  logic [6:0]   opcode_i,
    input  logic [2:0]   funct3_i,
    input  logic [6:0]   funct7_i,
    output instr_class_t instr_class_o,
    output logic         legal_o
);

    // Anything not matched below stays illegal with class CL_NONE.
    // andi ignores funct7 because those bits belong to the immediate.
    always_comb begin
        instr_class_o = CL_NONE;
        legal_o       = 1'b0;
        case (opcode_i)
            OP_LOAD: begin
                if (funct3_i == F3_WORD) begin
                    instr_class_o = CL_LOAD;
                    legal_o       = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3_i == F3_WORD) begin
                    instr_class_o = CL_STORE;
                    legal_o       = 1'b1;
                end
            end
            OP_R: begin
                if (((funct3_i == F3_ADDSUB) && ((funct7_i == F7_ZERO) || (funct7_i == F7_ALT))) ||
                    (((funct3_i == F3_OR) || (funct3_i == F3_SR)) && (funct7_i == F7_ZERO))) begin
                    instr_class_o = CL_RTYPE;
                    legal_o       = 1'b1;
                end
            end
            OP_I_ALU: begin
                if (funct3_i == F3_AND) begin
                    instr_class_o = CL_IALU;
                    legal_o       = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3_i == F3_BEQ) begin
                    instr_class_o = CL_BRANCH;
                    legal_o       = 1'b1;
                end
            end
            default: begin
                instr_class_o = CL_NONE;
                legal_o       = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle main control FSM for the RV32 subset core.
// Sequences the shared ALU, memory port, IR, PC and register file; stalls
// on mem_ready, traps illegal encodings and counts retired instructions.
// Ports:
//   clk, reset              : clock and async active-high reset
//   opcode, funct3, funct7  : IR fields
//   zero, mem_ready         : ALU zero flag, memory completion
//   pc_write .. result_src  : datapath enables and mux selects
//   illegal_instr           : sticky trap flag
//   instr_retired           : retired-instruction counter
//   state_out               : current state (debug)
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_retired,
    output logic [3:0]       state_out
);

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             in_trap;
    instr_class_t     instr_class;
    logic             legal;

    decodificador_legalidade u_decod (
        .opcode_i      (opcode),
        .funct3_i      (funct3),
        .funct7_i      (funct7),
        .instr_class_o (instr_class),
        .legal_o       (legal)
    );

    // State, trap flag and retire counter; reset aborts any instruction
    // in flight without counting it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next state and Moore-style output decode; only pc_write and ir_write
    // look at mem_ready/zero. Encodings 11-15 behave exactly like TRAP.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        retire     = 1'b0;
        in_trap    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (!legal) begin
                    state_d = S_TRAP;
                end else begin
                    case (instr_class)
                        CL_LOAD, CL_STORE: state_d = S_MEMADR;
                        CL_RTYPE:          state_d = S_EXECR;
                        CL_IALU:           state_d = S_EXECI;
                        CL_BRANCH:         state_d = S_BEQ;
                        default:           state_d = S_TRAP;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (legal && (instr_class == CL_LOAD))       state_d = S_MEMREAD;
                else if (legal && (instr_class == CL_STORE)) state_d = S_MEMWRITE;
                else                                         state_d = S_TRAP;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_RTYPE;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_AND;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                in_trap = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                in_trap = 1'b1;
                state_d = S_TRAP;
            end
        endcase
    end

    // The trap flag rises on the first edge spent in TRAP and is sticky.
    assign illegal_d = illegal_q | in_trap;
    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

    assign illegal_instr = illegal_q;
    assign instr_retired = retired_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo.
// Two instances (CNT_W=32 and CNT_W=4) share the same stimulus. The
// stimulus process walks each instruction through the cycle sequence
// listed for it, pushing the expected outputs of every cycle into a
// queue; a monitor pops and compares on each falling edge.
module tb_controle_multiciclo;

    localparam int K_LW   = 0;
    localparam int K_SW   = 1;
    localparam int K_R    = 2;
    localparam int K_ANDI = 3;
    localparam int K_BEQ  = 4;
    localparam int K_ILL  = 5;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw;
        logic        adr;
        logic        mrd;
        logic        mwr;
        logic        irw;
        logic        rgw;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [1:0]  op;
        logic [1:0]  rs;
        logic        ill;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
        logic [3:0]  st4;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;

    logic        pcw, adr, mrd, mwr, irw, rgw, ill;
    logic [1:0]  srcA, srcB, aluOp, resSrc;
    logic [31:0] cnt32;
    logic [3:0]  st32;

    logic        pcw4, adr4, mrd4, mwr4, irw4, rgw4, ill4;
    logic [1:0]  srcA4, srcB4, aluOp4, resSrc4;
    logic [3:0]  cnt4;
    logic [3:0]  st4;

    obs_t        expQ[$];
    int          nTests = 0;
    int          nFail  = 0;
    int          cyc    = 0;
    int unsigned mCnt   = 0;
    bit          mIll   = 1'b0;

    controle_multiciclo #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw), .adr_src(adr), .mem_read(mrd), .mem_write(mwr),
        .ir_write(irw), .reg_write(rgw), .alu_src_a(srcA), .alu_src_b(srcB),
        .alu_op(aluOp), .result_src(resSrc), .illegal_instr(ill),
        .instr_retired(cnt32), .state_out(st32)
    );

    controle_multiciclo #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw4), .adr_src(adr4), .mem_read(mrd4), .mem_write(mwr4),
        .ir_write(irw4), .reg_write(rgw4), .alu_src_a(srcA4), .alu_src_b(srcB4),
        .alu_op(aluOp4), .result_src(resSrc4), .illegal_instr(ill4),
        .instr_retired(cnt4), .state_out(st4)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit rb();
        return bit'($urandom_range(1, 0));
    endfunction

    // Which instruction the encoding is, taken straight from the list of
    // supported encodings.
    function automatic int classify(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
        if (opc == 7'h03 && f3 == 3'd2) return K_LW;
        if (opc == 7'h23 && f3 == 3'd2) return K_SW;
        if (opc == 7'h33 && ((f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ||
                             ((f3 == 3'd6 || f3 == 3'd5) && f7 == 7'h00))) return K_R;
        if (opc == 7'h13 && f3 == 3'd7) return K_ANDI;
        if (opc == 7'h63 && f3 == 3'd0) return K_BEQ;
        return K_ILL;
    endfunction

    // Expected outputs while sitting in state number st.
    function automatic obs_t expOut(int st, bit mr, bit z);
        obs_t e;
        e      = '0;
        e.st   = 4'(st);
        e.st4  = 4'(st);
        e.ill  = mIll;
        e.cnt  = mCnt;
        e.cnt4 = mCnt[3:0];
        case (st)
            0: begin e.mrd = 1; e.b = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
            1: begin e.a = 2'b01; e.b = 2'b01; end
            2: begin e.a = 2'b10; e.b = 2'b01; end
            3: begin e.adr = 1; e.mrd = 1; end
            4: begin e.rs = 2'b01; e.rgw = 1; end
            5: begin e.adr = 1; e.mwr = 1; end
            6: begin e.a = 2'b10; e.op = 2'b10; end
            7: begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b11; end
            8: begin e.rgw = 1; end
            9: begin e.a = 2'b10; e.op = 2'b01; e.pcw = z; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle in state st: drive the handshake inputs, queue the
    // expectation, and move to just after the next rising edge.
    task automatic applyStimulus(int st, bit mr, bit z);
        mem_ready = mr;
        zero      = z;
        expQ.push_back(expOut(st, mr, z));
        @(posedge clk);
        #1;
    endtask

    // Reset raised between edges; outputs must show FETCH at once.
    task automatic doReset();
        mem_ready = 1'b0;
        zero      = rb();
        #1;
        reset = 1'b1;
        mCnt  = 0;
        mIll  = 1'b0;
        expQ.push_back(expOut(0, 1'b0, zero));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fetchPhase(int fetchWait);
        for (int i = 0; i < fetchWait; i++) begin
            opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            applyStimulus(0, 1'b0, rb());
        end
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        applyStimulus(0, 1'b1, rb());
    endtask

    task automatic runWord(logic [31:0] w, int fetchWait, int memWait, bit z, int trapHold);
        int k;
        fetchPhase(fetchWait);
        opcode = w[6:0];
        funct3 = w[14:12];
        funct7 = w[31:25];
        k = classify(w[6:0], w[14:12], w[31:25]);
        applyStimulus(1, rb(), rb());
        case (k)
            K_LW: begin
                applyStimulus(2, rb(), rb());
                for (int i = 0; i < memWait; i++) applyStimulus(3, 1'b0, rb());
                applyStimulus(3, 1'b1, rb());
                applyStimulus(4, rb(), rb());
                mCnt++;
            end
            K_SW: begin
                applyStimulus(2, rb(), rb());
                for (int i = 0; i < memWait; i++) applyStimulus(5, 1'b0, rb());
                applyStimulus(5, 1'b1, rb());
                mCnt++;
            end
            K_R: begin
                applyStimulus(6, rb(), rb());
                applyStimulus(8, rb(), rb());
                mCnt++;
            end
            K_ANDI: begin
                applyStimulus(7, rb(), rb());
                applyStimulus(8, rb(), rb());
                mCnt++;
            end
            K_BEQ: begin
                applyStimulus(9, rb(), z);
                mCnt++;
            end
            default: begin
                applyStimulus(10, rb(), rb());
                mIll = 1'b1;
                for (int i = 0; i < trapHold; i++) applyStimulus(10, rb(), rb());
                doReset();
            end
        endcase
    endtask

    // A store aborted by reset while it waits for memory.
    task automatic runSwAbort();
        fetchPhase(0);
        opcode = 7'h23; funct3 = 3'd2; funct7 = 7'h00;
        applyStimulus(1, 1'b1, rb());
        applyStimulus(2, 1'b1, rb());
        applyStimulus(5, 1'b0, rb());
        applyStimulus(5, 1'b0, rb());
        doReset();
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 5);
        case (sel)
            0: w[6:0] = 7'h03;
            1: w[6:0] = 7'h23;
            2: w[6:0] = 7'h33;
            3: w[6:0] = 7'h13;
            4: w[6:0] = 7'h63;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) begin
            case (sel)
                0, 1: w[14:12] = 3'd2;
                3:    w[14:12] = 3'd7;
                4:    w[14:12] = 3'd0;
                2: begin
                    case ($urandom_range(0, 2))
                        0: w[14:12] = 3'd0;
                        1: w[14:12] = 3'd6;
                        default: w[14:12] = 3'd5;
                    endcase
                    case ($urandom_range(0, 2))
                        0: w[31:25] = 7'h00;
                        1: w[31:25] = 7'h20;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        return w;
    endfunction

    // Scoreboard monitor: compares every queued cycle on the falling edge.
    task automatic checkOutput();
        obs_t e, a;
        e = expQ.pop_front();
        a = '{st: st32, pcw: pcw, adr: adr, mrd: mrd, mwr: mwr, irw: irw, rgw: rgw,
              a: srcA, b: srcB, op: aluOp, rs: resSrc, ill: ill, cnt: cnt32,
              cnt4: cnt4, st4: st4};
        nTests++;
        if (a !== e) begin
            nFail++;
            $display("[TB] FAIL outputs cycle %0d: got %h required %h (st %0d/%0d cnt %0d/%0d)",
                     cyc, a, e, a.st, e.st, a.cnt, e.cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (expQ.size() > 0) checkOutput();
        end
    end

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        runWord(32'h002081B3, 0, 0, 1'b0, 0);   // add
        runWord(32'h0000A103, 3, 2, 1'b0, 0);   // lw with stalls
        runWord(32'h00208063, 0, 0, 1'b1, 0);   // beq taken
        runWord(32'h00208063, 0, 0, 1'b0, 0);   // beq not taken
        runWord(32'h4020D1B3, 0, 0, 1'b0, 3);   // sra: illegal
        runWord(32'h0000007F, 1, 0, 1'b0, 3);   // opcode 0x7F: illegal
        for (int i = 0; i < 16; i++) runWord(32'h0FF0F093, 0, 0, 1'b0, 0);
        runWord(32'h0020A023, 0, 1, 1'b0, 0);   // sw
        runSwAbort();

        for (int n = 0; n < 200; n++)
            runWord(randWord(), $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                    $urandom_range(1, 3));

        @(negedge clk);
        #1;
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("[TB] FAIL queue drain: got %0d pending, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
